uart_link_ctrl: RTL and testbench
=================================

# uart_link_ctrl

Sequencing controller for the UART subsystem. It owns every enable and strobe input of `uart_top` (`tx_wr_en`, `tx_rd_en`, `tx_start`, `rx_wr_en`, `rx_rd_en`, `rx_start`):
- drains the TX FIFO into the transmitter frame by frame;
- commits received frames into the RX FIFO, filtering errored frames and overruns;
- gates host push/pop requests against FIFO flags;
- keeps saturating link statistics.

It sits between the host register interface and `uart_top`.

## Interface
Parameters:
- `START_TIMEOUT`, default 1024: clk cycles allowed from `tx_start` until `tx_busy` is seen high.
- `DROP_ERR`, default 1: 1 = frames with a parity or framing error are not written to the RX FIFO; 0 = they are written and counted.
- `CNT_WD`, default 16: width of the statistics counters.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `tx_en` in 1: level; enables automatic TX draining.
- `rx_en` in 1: level; enables reception.
- `host_wr` in 1: host requests a push of `din` into the TX FIFO this cycle.
- `host_rd` in 1: host requests a pop from the RX FIFO this cycle.
- `clr_stat` in 1: pulse; clears the counters and `tx_stall`.
- `tx_full`, `tx_empty`, `tx_busy`, `tx_done` in 1 each: from `uart_top`.
- `rx_full`, `rx_empty`, `rx_done`, `rx_busy` in 1 each: from `uart_top`.
- `framing_error_flag`, `parity_error_flag` in 1 each: from `uart_top`, valid with `rx_done`.
- `tx_wr_en`, `tx_rd_en`, `tx_start` out 1 each: to `uart_top`.
- `rx_wr_en`, `rx_rd_en`, `rx_start` out 1 each: to `uart_top`.
- `wr_reject`, `rd_reject` out 1 each: 1-cycle pulse when a host request is refused.
- `tx_stall` out 1: sticky; the transmitter did not start within `START_TIMEOUT`.
- `tx_cnt`, `rx_cnt`, `ovr_cnt`, `perr_cnt`, `ferr_cnt` out `CNT_WD` each: frames sent, frames committed, overruns, parity errors, framing errors.

## Operation
Host gating (combinational):
- `tx_wr_en = host_wr & ~tx_full`.
- `rx_rd_en = host_rd & ~rx_empty`.
- `wr_reject` is registered: high the cycle after `host_wr & tx_full`.
- `rd_reject` is registered: high the cycle after `host_rd & rx_empty`.

TX state machine; all outputs are registered:
- IDLE → POP when `tx_en & ~tx_empty & ~tx_busy & ~tx_stall`. POP drives `tx_rd_en` for 1 cycle; it is OR'd with nothing, since the host never pops TX.
- POP → LOAD. LOAD is 1 wait cycle for the FIFO read data to settle on the TX `din`.
- LOAD → START. START drives `tx_start` for 1 cycle and loads the timeout counter with `START_TIMEOUT-1`.
- START → WAIT_BUSY. When `tx_busy` = 1, go to WAIT_DONE. When the counter reaches 0 with `tx_busy` still low, set `tx_stall` and go to IDLE; that popped byte is lost.
- WAIT_DONE → IDLE on `tx_done`; `tx_cnt` increments.
- `tx_en` deasserting mid-frame does not abort the frame; it only blocks the next IDLE→POP.

RX path:
- `rx_start` is a registered copy of `rx_en`.
- On a cycle with `rx_done` = 1, evaluate with priority: framing error, parity error, `rx_full`.
- Framing error: `ferr_cnt` increments.
- Parity error: `perr_cnt` increments. A frame with both errors increments both counters.
- Errored frame with `DROP_ERR` = 1: no write.
- Otherwise, if `rx_full` = 1: `ovr_cnt` increments, no write.
- Otherwise: `rx_wr_en` pulses on the next cycle and `rx_cnt` increments. The RX `dout` must remain stable until the next frame completes.

Counters:
- All counters saturate at 2^`CNT_WD`-1 and never wrap.
- `clr_stat` has priority over an increment in the same cycle.

## Timing
Reset values:
- All outputs are 0 after the first clock edge with `rst` = 1.
- The TX FSM is in IDLE, the timeout counter is 0, `tx_stall` = 0.
- `rst` mid-frame returns the FSM to IDLE immediately. A pending `rx_wr_en` is cancelled.

TX sequence:
- Latency from `tx_empty` falling (with `tx_en` set and the line idle) to the `tx_start` pulse: 3 cycles (POP, LOAD, START).
- Minimum gap between a `tx_done` and the next `tx_start`: 3 cycles.

RX sequence:
- `rx_wr_en` is asserted exactly 1 cycle after `rx_done`, for 1 cycle.
- The `rx_full` sample used is the one on the `rx_done` cycle.

Simultaneous events:
- `host_rd` popping the RX FIFO while `rx_done` arrives with `rx_full` = 1 still counts as an overrun. No lookahead is applied.
- `tx_stall` blocks TX until `clr_stat` or `rst`.

## Test plan
- Push 3 bytes 0xA5, 0x3C, 0x0F with `tx_en` = 1. Required:
  - `tx_rd_en` pulses 3 times;
  - `tx_start` occurs 2 cycles after each `tx_rd_en`;
  - the looped-back RX FIFO holds the same 3 bytes in order;
  - `tx_cnt` = 3 and `rx_cnt` = 3.
- Force `parity_error_flag` = 1 with `rx_done` on 1 frame, `DROP_ERR` = 1. Required: no `rx_wr_en`, `perr_cnt` = 1, `rx_cnt` unchanged. Repeat with `DROP_ERR` = 0: the write occurs and `perr_cnt` = 2.
- Pulse `rx_done` with `rx_full` = 1. Required: `ovr_cnt` = 1 and no `rx_wr_en`. Then `host_rd` with `rx_empty` = 1 gives a `rd_reject` pulse; `host_wr` with `tx_full` = 1 gives a `wr_reject` pulse and `tx_wr_en` stays 0.
- Hold `tx_busy` = 0 after `tx_start`, with `START_TIMEOUT` = 8. Required:
  - `tx_stall` rises 8 cycles after `tx_start`;
  - no further `tx_rd_en` occurs while `tx_empty` = 0;
  - `clr_stat` resumes draining.
- Assert `rst` during WAIT_DONE. Required: all outputs are 0 the next cycle, and no stale `tx_start` follows reset release.
- With `CNT_WD` = 2, complete 5 received frames. Required: `rx_cnt` saturates at 3. `clr_stat` together with `rx_done` in the same cycle leaves `rx_cnt` = 0.

Source files
------------

// File: rtl/uart_link_ctrl.sv
// Sequencing controller between the host register interface and uart_top:
// drains the TX FIFO, commits received frames, gates host requests, keeps stats.
module uart_link_ctrl #(
  parameter int START_TIMEOUT = 1024,
  parameter bit DROP_ERR      = 1'b1,
  parameter int CNT_WD        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_en,
  input  logic              rx_en,
  input  logic              host_wr,
  input  logic              host_rd,
  input  logic              clr_stat,
  input  logic              tx_full,
  input  logic              tx_empty,
  input  logic              tx_busy,
  input  logic              tx_done,
  input  logic              rx_full,
  input  logic              rx_empty,
  input  logic              rx_done,
  input  logic              rx_busy,
  input  logic              framing_error_flag,
  input  logic              parity_error_flag,
  output logic              tx_wr_en,
  output logic              tx_rd_en,
  output logic              tx_start,
  output logic              rx_wr_en,
  output logic              rx_rd_en,
  output logic              rx_start,
  output logic              wr_reject,
  output logic              rd_reject,
  output logic              tx_stall,
  output logic [CNT_WD-1:0] tx_cnt,
  output logic [CNT_WD-1:0] rx_cnt,
  output logic [CNT_WD-1:0] ovr_cnt,
  output logic [CNT_WD-1:0] perr_cnt,
  output logic [CNT_WD-1:0] ferr_cnt
);

  localparam int TMO_W = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(START_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_LOAD,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } tx_state_t;

  tx_state_t        state;
  logic [TMO_W-1:0] tmo;
  logic             frame_err;
  logic             drop_frame;
  logic             unused_inputs;

  function automatic logic [CNT_WD-1:0] sat_inc(input logic [CNT_WD-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Host requests go straight through when the FIFO flag allows them.
  assign tx_wr_en      = host_wr & ~tx_full;
  assign rx_rd_en      = host_rd & ~rx_empty;
  assign frame_err     = framing_error_flag | parity_error_flag;
  assign drop_frame    = frame_err & DROP_ERR;
  assign unused_inputs = rx_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_reject <= 1'b0;
      rd_reject <= 1'b0;
    end else begin
      wr_reject <= host_wr & tx_full;
      rd_reject <= host_rd & rx_empty;
    end
  end

  // One frame per pass: pop, let FIFO data settle, start, then wait for busy/done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      tmo      <= '0;
      tx_rd_en <= 1'b0;
      tx_start <= 1'b0;
      tx_stall <= 1'b0;
      tx_cnt   <= '0;
    end else begin
      tx_rd_en <= 1'b0;
      tx_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (tx_en & ~tx_empty & ~tx_busy & ~tx_stall) begin
            state    <= S_POP;
            tx_rd_en <= 1'b1;
          end
        end
        S_POP:  state <= S_LOAD;
        S_LOAD: begin
          state    <= S_START;
          tx_start <= 1'b1;
          tmo      <= TMO_LOAD;
        end
        S_START: begin
          if (tx_busy) begin
            state <= S_WAIT_DONE;
          end else begin
            state <= S_WAIT_BUSY;
            if (tmo != '0) tmo <= tmo - 1'b1;
          end
        end
        S_WAIT_BUSY: begin
          if (tx_busy) begin
            state <= S_WAIT_DONE;
          end else if (tmo == '0) begin
            // The popped byte is abandoned; TX stays blocked until cleared.
            state    <= S_IDLE;
            tx_stall <= 1'b1;
          end else begin
            tmo <= tmo - 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (tx_done) begin
            state  <= S_IDLE;
            tx_cnt <= sat_inc(tx_cnt);
          end
        end
        default: state <= S_IDLE;
      endcase
      if (clr_stat) begin
        tx_stall <= 1'b0;
        tx_cnt   <= '0;
      end
    end
  end

  // Error counters first, then drop/overrun/commit decided on the rx_done cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_start <= 1'b0;
      rx_wr_en <= 1'b0;
      rx_cnt   <= '0;
      ovr_cnt  <= '0;
      perr_cnt <= '0;
      ferr_cnt <= '0;
    end else begin
      rx_start <= rx_en;
      rx_wr_en <= 1'b0;
      if (rx_done) begin
        if (framing_error_flag) ferr_cnt <= sat_inc(ferr_cnt);
        if (parity_error_flag)  perr_cnt <= sat_inc(perr_cnt);
        if (!drop_frame) begin
          if (rx_full) begin
            ovr_cnt <= sat_inc(ovr_cnt);
          end else begin
            rx_wr_en <= 1'b1;
            rx_cnt   <= sat_inc(rx_cnt);
          end
        end
      end
      if (clr_stat) begin
        rx_cnt   <= '0;
        ovr_cnt  <= '0;
        perr_cnt <= '0;
        ferr_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_link_ctrl.sv
// Bench for uart_link_ctrl: a small uart_top loopback model for instance A,
// a directly driven RX-only instance B (DROP_ERR=0, CNT_WD=2), scoreboard monitor.
module tb_uart_link_ctrl;

  localparam int FRAME_LEN = 6;
  localparam int K_PUSH    = 0;
  localparam int K_POP     = 1;
  localparam int K_FRAME_A = 2;
  localparam int K_FRAME_B = 3;
  localparam int K_CLR     = 4;
  localparam int K_FULLWR  = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       tx_en = 1'b0, rx_en = 1'b0, host_wr = 1'b0, host_rd = 1'b0, clr_stat = 1'b0;
  logic [7:0] din = 8'h00;
  logic       stim_rx_done = 1'b0, stim_perr = 1'b0, stim_ferr = 1'b0;
  logic       stim_rx_full = 1'b0, stim_tx_full = 1'b0, hold_busy_low = 1'b0;
  logic       b_rx_done = 1'b0, b_perr = 1'b0, b_clr = 1'b0;

  logic       m_tx_busy = 1'b0, m_tx_done = 1'b0, m_rx_done = 1'b0;
  logic       m_tx_full = 1'b0, m_rx_full = 1'b0;
  logic       tx_empty = 1'b1, rx_empty = 1'b1;
  logic       tx_full, rx_full, rx_done;
  logic [7:0] tx_byte = 8'h00, rx_byte = 8'h00;
  int         phase = 0;

  logic       s_tx_wr_en = 1'b0, s_tx_rd_en = 1'b0, s_tx_start = 1'b0;
  logic       s_rx_wr_en = 1'b0, s_rx_rd_en = 1'b0;
  logic [7:0] s_din = 8'h00;

  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] exp_rx_q[$];
  logic       wr_exp_q[$];
  logic       wr_exp_b[$];

  int check_cnt = 0, pass_cnt = 0;
  int cyc = 0, last_rd = -100, last_start = -100, rd_pulses = 0, start_pulses = 0;
  logic prev_stall = 1'b0;

  logic        tx_wr_en, tx_rd_en, tx_start, rx_wr_en, rx_rd_en, rx_start;
  logic        wr_reject, rd_reject, tx_stall;
  logic [15:0] tx_cnt, rx_cnt, ovr_cnt, perr_cnt, ferr_cnt;

  logic        b_tx_wr_en, b_tx_rd_en, b_tx_start, b_rx_wr_en, b_rx_rd_en, b_rx_start;
  logic        b_wr_reject, b_rd_reject, b_tx_stall;
  logic [1:0]  b_tx_cnt, b_rx_cnt, b_ovr_cnt, b_perr_cnt, b_ferr_cnt;

  assign tx_full = m_tx_full | stim_tx_full;
  assign rx_full = m_rx_full | stim_rx_full;
  assign rx_done = m_rx_done | stim_rx_done;

  uart_link_ctrl #(.START_TIMEOUT(8), .DROP_ERR(1'b1), .CNT_WD(16)) dut_a (
    .clk(clk), .rst(rst), .tx_en(tx_en), .rx_en(rx_en),
    .host_wr(host_wr), .host_rd(host_rd), .clr_stat(clr_stat),
    .tx_full(tx_full), .tx_empty(tx_empty), .tx_busy(m_tx_busy), .tx_done(m_tx_done),
    .rx_full(rx_full), .rx_empty(rx_empty), .rx_done(rx_done), .rx_busy(1'b0),
    .framing_error_flag(stim_ferr), .parity_error_flag(stim_perr),
    .tx_wr_en(tx_wr_en), .tx_rd_en(tx_rd_en), .tx_start(tx_start),
    .rx_wr_en(rx_wr_en), .rx_rd_en(rx_rd_en), .rx_start(rx_start),
    .wr_reject(wr_reject), .rd_reject(rd_reject), .tx_stall(tx_stall),
    .tx_cnt(tx_cnt), .rx_cnt(rx_cnt), .ovr_cnt(ovr_cnt),
    .perr_cnt(perr_cnt), .ferr_cnt(ferr_cnt)
  );

  uart_link_ctrl #(.DROP_ERR(1'b0), .CNT_WD(2)) dut_b (
    .clk(clk), .rst(rst), .tx_en(1'b0), .rx_en(1'b1),
    .host_wr(1'b0), .host_rd(1'b0), .clr_stat(b_clr),
    .tx_full(1'b0), .tx_empty(1'b1), .tx_busy(1'b0), .tx_done(1'b0),
    .rx_full(1'b0), .rx_empty(1'b1), .rx_done(b_rx_done), .rx_busy(1'b0),
    .framing_error_flag(1'b0), .parity_error_flag(b_perr),
    .tx_wr_en(b_tx_wr_en), .tx_rd_en(b_tx_rd_en), .tx_start(b_tx_start),
    .rx_wr_en(b_rx_wr_en), .rx_rd_en(b_rx_rd_en), .rx_start(b_rx_start),
    .wr_reject(b_wr_reject), .rd_reject(b_rd_reject), .tx_stall(b_tx_stall),
    .tx_cnt(b_tx_cnt), .rx_cnt(b_rx_cnt), .ovr_cnt(b_ovr_cnt),
    .perr_cnt(b_perr_cnt), .ferr_cnt(b_ferr_cnt)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    check_cnt++;
    if (actual == expected) pass_cnt++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // One-cycle stimulus pulse; expectations are queued at issue time.
  task automatic applyStimulus(input int kind, input logic [7:0] arg, input logic exp_bit);
    @(negedge clk);
    case (kind)
      K_PUSH: begin
        host_wr = 1'b1;
        din     = arg;
        if (exp_bit) exp_rx_q.push_back(arg);
      end
      K_POP:  host_rd = 1'b1;
      K_FRAME_A: begin
        stim_rx_done = 1'b1;
        stim_perr    = arg[0];
        stim_ferr    = arg[1];
        stim_rx_full = arg[2];
        wr_exp_q.push_back(exp_bit);
      end
      K_FRAME_B: begin
        b_rx_done = 1'b1;
        b_perr    = arg[0];
        b_clr     = arg[3];
        wr_exp_b.push_back(exp_bit);
      end
      K_CLR: clr_stat = 1'b1;
      K_FULLWR: begin
        stim_tx_full = 1'b1;
        host_wr      = 1'b1;
        din          = arg;
      end
      default: ;
    endcase
    @(negedge clk);
    host_wr = 1'b0; host_rd = 1'b0; clr_stat = 1'b0;
    stim_rx_done = 1'b0; stim_perr = 1'b0; stim_ferr = 1'b0;
    stim_rx_full = 1'b0; stim_tx_full = 1'b0;
    b_rx_done = 1'b0; b_perr = 1'b0; b_clr = 1'b0;
  endtask

  // What uart_top saw at each rising edge.
  always @(posedge clk) begin
    s_tx_wr_en <= tx_wr_en;
    s_tx_rd_en <= tx_rd_en;
    s_tx_start <= tx_start;
    s_rx_wr_en <= rx_wr_en;
    s_rx_rd_en <= rx_rd_en;
    s_din      <= din;
  end

  // uart_top stand-in: FIFOs as queues, fixed-length frame, TX looped back to RX.
  always @(negedge clk) begin
    if (s_tx_wr_en) tx_q.push_back(s_din);
    if (s_tx_rd_en && tx_q.size() > 0) tx_byte = tx_q.pop_front();
    if (s_rx_wr_en) rx_q.push_back(rx_byte);
    if (s_rx_rd_en && rx_q.size() > 0) void'(rx_q.pop_front());
    m_tx_done = 1'b0;
    m_rx_done = 1'b0;
    if (s_tx_start && !hold_busy_low) begin
      phase = FRAME_LEN;
    end else if (phase > 0) begin
      phase--;
      if (phase == 0) begin
        m_tx_done = 1'b1;
        m_rx_done = 1'b1;
        rx_byte   = tx_byte;
        wr_exp_q.push_back(1'b1);
      end
    end
    m_tx_busy = (phase > 0);
    tx_empty  = (tx_q.size() == 0);
    m_tx_full = (tx_q.size() >= 4);
    rx_empty  = (rx_q.size() == 0);
    m_rx_full = (rx_q.size() >= 8);
  end

  // Monitor: pops expectations whenever the DUT presents a write, read or strobe.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (tx_rd_en) begin
      rd_pulses++;
      last_rd = cyc;
    end
    if (tx_start) begin
      start_pulses++;
      checkOutput("rd_to_start_gap", cyc - last_rd, 2);
      last_start = cyc;
    end
    if (tx_stall && !prev_stall) checkOutput("start_to_stall_gap", cyc - last_start, 8);
    prev_stall = tx_stall;
    if (host_wr && tx_full) checkOutput("tx_wr_en_gated", int'(tx_wr_en), 0);
    if (host_rd && rx_empty) checkOutput("rx_rd_en_gated", int'(rx_rd_en), 0);
    if (rx_done) begin
      if (wr_exp_q.size() > 0) checkOutput("rx_wr_en_a", int'(rx_wr_en), int'(wr_exp_q.pop_front()));
      else begin
        check_cnt++;
        $display("[TB] FAIL rx_frame_a: rx_done with nothing queued, rx_wr_en=%0b", rx_wr_en);
      end
    end
    if (b_rx_done) begin
      if (wr_exp_b.size() > 0) checkOutput("rx_wr_en_b", int'(b_rx_wr_en), int'(wr_exp_b.pop_front()));
      else begin
        check_cnt++;
        $display("[TB] FAIL rx_frame_b: rx_done with nothing queued, rx_wr_en=%0b", b_rx_wr_en);
      end
    end
    if (rx_rd_en) begin
      if (exp_rx_q.size() > 0) begin
        checkOutput("rx_byte", (rx_q.size() > 0) ? int'(rx_q[0]) : -1, int'(exp_rx_q.pop_front()));
      end else begin
        check_cnt++;
        $display("[TB] FAIL rx_byte: unexpected pop, fifo depth %0d", rx_q.size());
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d", pass_cnt, check_cnt);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int base;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_ctrl_a", int'({tx_wr_en, tx_rd_en, tx_start, rx_wr_en, rx_rd_en,
                                      rx_start, wr_reject, rd_reject, tx_stall}), 0);
    checkOutput("reset_cnt_a", int'(tx_cnt | rx_cnt | ovr_cnt | perr_cnt | ferr_cnt), 0);
    checkOutput("reset_b", int'({b_rx_wr_en, b_rx_start, b_tx_stall, b_rx_cnt, b_perr_cnt}), 0);
    @(negedge clk);
    rst = 1'b0; tx_en = 1'b1; rx_en = 1'b1;

    // Loopback of three bytes
    applyStimulus(K_PUSH, 8'hA5, 1'b1);
    applyStimulus(K_PUSH, 8'h3C, 1'b1);
    applyStimulus(K_PUSH, 8'h0F, 1'b1);
    for (int i = 0; i < 300 && tx_cnt != 16'd3; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    checkOutput("tx_cnt_3", int'(tx_cnt), 3);
    checkOutput("rx_cnt_3", int'(rx_cnt), 3);
    checkOutput("tx_rd_en_pulses", rd_pulses, 3);
    checkOutput("rx_start_follows_en", int'(rx_start), 1);
    repeat (3) applyStimulus(K_POP, 8'h00, 1'b0);

    // Errored frames and overrun with DROP_ERR=1
    applyStimulus(K_FRAME_A, 8'b001, 1'b0);
    checkOutput("perr_cnt_1", int'(perr_cnt), 1);
    checkOutput("rx_cnt_unchanged", int'(rx_cnt), 3);
    applyStimulus(K_FRAME_A, 8'b011, 1'b0);
    checkOutput("perr_cnt_2", int'(perr_cnt), 2);
    checkOutput("ferr_cnt_1", int'(ferr_cnt), 1);
    applyStimulus(K_FRAME_A, 8'b100, 1'b0);
    checkOutput("ovr_cnt_1", int'(ovr_cnt), 1);
    checkOutput("rx_cnt_after_ovr", int'(rx_cnt), 3);

    // Host request rejects
    applyStimulus(K_POP, 8'h00, 1'b0);
    checkOutput("rd_reject_pulse", int'(rd_reject), 1);
    @(negedge clk);
    checkOutput("rd_reject_clears", int'(rd_reject), 0);
    applyStimulus(K_FULLWR, 8'h77, 1'b0);
    checkOutput("wr_reject_pulse", int'(wr_reject), 1);
    @(negedge clk);
    checkOutput("wr_reject_clears", int'(wr_reject), 0);

    // Start timeout: busy never rises
    hold_busy_low = 1'b1;
    applyStimulus(K_PUSH, 8'h11, 1'b0);
    for (int i = 0; i < 100 && !tx_stall; i++) @(negedge clk);
    checkOutput("tx_stall_set", int'(tx_stall), 1);
    applyStimulus(K_PUSH, 8'h22, 1'b1);
    base = rd_pulses;
    repeat (30) @(negedge clk);
    checkOutput("no_pop_while_stalled", rd_pulses - base, 0);
    checkOutput("tx_stall_sticky", int'(tx_stall), 1);
    hold_busy_low = 1'b0;
    applyStimulus(K_CLR, 8'h00, 1'b0);
    checkOutput("tx_stall_cleared", int'(tx_stall), 0);
    for (int i = 0; i < 200 && tx_cnt != 16'd1; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    checkOutput("tx_cnt_after_resume", int'(tx_cnt), 1);
    checkOutput("rx_cnt_after_resume", int'(rx_cnt), 1);
    applyStimulus(K_POP, 8'h00, 1'b0);

    // Reset in the middle of a frame
    applyStimulus(K_PUSH, 8'h33, 1'b1);
    for (int i = 0; i < 50 && !m_tx_busy; i++) @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midframe_reset_ctrl", int'({tx_wr_en, tx_rd_en, tx_start, rx_wr_en, rx_rd_en,
                                             rx_start, wr_reject, rd_reject, tx_stall}), 0);
    checkOutput("midframe_reset_cnt", int'(tx_cnt | rx_cnt | ovr_cnt | perr_cnt | ferr_cnt), 0);
    @(negedge clk);
    rst = 1'b0;
    base = start_pulses;
    repeat (30) @(negedge clk);
    checkOutput("no_stale_tx_start", start_pulses - base, 0);
    checkOutput("tx_cnt_after_reset", int'(tx_cnt), 0);
    checkOutput("rx_cnt_after_reset", int'(rx_cnt), 1);
    applyStimulus(K_POP, 8'h00, 1'b0);

    // Instance B: errored frames kept, 2-bit counters saturate
    applyStimulus(K_FRAME_B, 8'b0001, 1'b1);
    checkOutput("b_perr_cnt_1", int'(b_perr_cnt), 1);
    checkOutput("b_rx_cnt_1", int'(b_rx_cnt), 1);
    applyStimulus(K_FRAME_B, 8'b0001, 1'b1);
    checkOutput("b_perr_cnt_2", int'(b_perr_cnt), 2);
    repeat (3) applyStimulus(K_FRAME_B, 8'b0000, 1'b1);
    checkOutput("b_rx_cnt_saturated", int'(b_rx_cnt), 3);
    applyStimulus(K_FRAME_B, 8'b1000, 1'b1);
    checkOutput("b_clr_beats_inc", int'(b_rx_cnt), 0);
    checkOutput("b_perr_cleared", int'(b_perr_cnt), 0);

    repeat (3) @(negedge clk);
    checkOutput("exp_bytes_left", exp_rx_q.size(), 0);
    checkOutput("wr_exp_a_left", wr_exp_q.size(), 0);
    checkOutput("wr_exp_b_left", wr_exp_b.size(), 0);
    $display("[TB] %0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
